// File: rtl/pipe_pkg.sv
// Shared constants and types for the MEM/WB pipeline stage.
package pipe_pkg;

  // Datapath geometry; the stage is only built for a 32-bit datapath.
  localparam int WIDTH = 32;
  localparam int RN_W  = 5;

  // Register-file writeback source select.
  localparam logic [2:0] RF_SRC_ALU   = 3'd0;
  localparam logic [2:0] RF_SRC_DM    = 3'd1;
  localparam logic [2:0] RF_SRC_PC4   = 3'd2;
  localparam logic [2:0] RF_SRC_HI    = 3'd3;
  localparam logic [2:0] RF_SRC_LO    = 3'd4;
  localparam logic [2:0] RF_SRC_CP0   = 3'd5;
  localparam logic [2:0] RF_SRC_CNT   = 3'd6;
  localparam logic [2:0] RF_SRC_MULLO = 3'd7;

  // Load size select; 2'b11 behaves as a word load.
  localparam logic [1:0] CUT_WORD     = 2'b00;
  localparam logic [1:0] CUT_HALF     = 2'b01;
  localparam logic [1:0] CUT_BYTE     = 2'b10;
  localparam logic [1:0] CUT_WORD_ALT = 2'b11;

  // HI source select.
  localparam logic [1:0] HI_SRC_A    = 2'b00;
  localparam logic [1:0] HI_SRC_MUL  = 2'b01;
  localparam logic [1:0] HI_SRC_R    = 2'b10;
  localparam logic [1:0] HI_SRC_HOLD = 2'b11;

  // LO source select.
  localparam logic [1:0] LO_SRC_A    = 2'b00;
  localparam logic [1:0] LO_SRC_MUL  = 2'b01;
  localparam logic [1:0] LO_SRC_Q    = 2'b10;
  localparam logic [1:0] LO_SRC_HOLD = 2'b11;

  // Contents of the MEM/WB pipeline register.
  typedef struct packed {
    logic             valid;
    logic             w_rf;
    logic             w_hi;
    logic             w_lo;
    logic             sign;
    logic [2:0]       rfsource;
    logic [1:0]       cuttersource;
    logic [1:0]       hisource;
    logic [1:0]       losource;
    logic [RN_W-1:0]  rn;
    logic [WIDTH-1:0] alu;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] dm;
    logic [WIDTH-1:0] pc4;
    logic [WIDTH-1:0] cp0;
    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] muler_hi;
    logic [WIDTH-1:0] muler_lo;
  } wb_reg_t;

endpackage

// File: rtl/pipe_load_cutter.sv
// Load-data cutter: picks a byte/halfword lane out of the loaded word and
// sign- or zero-extends it. Purely combinational.
module pipe_load_cutter
  import pipe_pkg::*;
(
  input  logic [WIDTH-1:0] dm,
  input  logic [1:0]       addr_lo,
  input  logic [1:0]       size,
  input  logic             sign,
  output logic [WIDTH-1:0] cut
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane extraction; a misaligned halfword only looks at addr_lo[1].
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    case (addr_lo)
      2'b00:   byte_s = dm[7:0];
      2'b01:   byte_s = dm[15:8];
      2'b10:   byte_s = dm[23:16];
      2'b11:   byte_s = dm[31:24];
      default: byte_s = dm[7:0];
    endcase
    if (addr_lo[1]) begin
      half_s = dm[31:16];
    end else begin
      half_s = dm[15:0];
    end
  end

  // Size select and extension; word sizes pass the loaded data untouched.
  always_comb begin
    cut = dm;
    case (size)
      CUT_WORD:     cut = dm;
      CUT_HALF:     cut = {{16{sign & half_s[15]}}, half_s};
      CUT_BYTE:     cut = {{24{sign & byte_s[7]}}, byte_s};
      CUT_WORD_ALT: cut = dm;
      default:      cut = dm;
    endcase
  end

endmodule

// File: rtl/pipe_wb_stage.sv
// MEM/WB pipeline register and writeback stage. Owns the architectural
// HI/LO registers and drives the register-file write port.
module pipe_wb_stage #(
  parameter int WIDTH = 32,
  parameter int RN_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic             m_valid,
  input  logic             m_w_rf,
  input  logic             m_w_hi,
  input  logic             m_w_lo,
  input  logic             m_sign,
  input  logic [2:0]       m_rfsource,
  input  logic [1:0]       m_cuttersource,
  input  logic [1:0]       m_hisource,
  input  logic [1:0]       m_losource,
  input  logic [RN_W-1:0]  m_rn,
  input  logic [WIDTH-1:0] m_alu,
  input  logic [WIDTH-1:0] m_a,
  input  logic [WIDTH-1:0] m_dm,
  input  logic [WIDTH-1:0] m_pc4,
  input  logic [WIDTH-1:0] m_cp0,
  input  logic [WIDTH-1:0] m_counter,
  input  logic [WIDTH-1:0] m_q,
  input  logic [WIDTH-1:0] m_r,
  input  logic [WIDTH-1:0] m_muler_hi,
  input  logic [WIDTH-1:0] m_muler_lo,
  output logic             rf_we,
  output logic [RN_W-1:0]  rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  output logic [WIDTH-1:0] hi_q,
  output logic [WIDTH-1:0] lo_q,
  output logic             wb_valid
);

  import pipe_pkg::*;

  wb_reg_t          m_in_s;
  wb_reg_t          wb_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] hi_next_s;
  logic [WIDTH-1:0] lo_next_s;
  logic [WIDTH-1:0] cut_s;
  logic             commit_s;

  // Pack the MEM-stage inputs into the pipeline register layout.
  always_comb begin
    m_in_s              = '0;
    m_in_s.valid        = m_valid;
    m_in_s.w_rf         = m_w_rf;
    m_in_s.w_hi         = m_w_hi;
    m_in_s.w_lo         = m_w_lo;
    m_in_s.sign         = m_sign;
    m_in_s.rfsource     = m_rfsource;
    m_in_s.cuttersource = m_cuttersource;
    m_in_s.hisource     = m_hisource;
    m_in_s.losource     = m_losource;
    m_in_s.rn           = m_rn;
    m_in_s.alu          = m_alu;
    m_in_s.a            = m_a;
    m_in_s.dm           = m_dm;
    m_in_s.pc4          = m_pc4;
    m_in_s.cp0          = m_cp0;
    m_in_s.counter      = m_counter;
    m_in_s.q            = m_q;
    m_in_s.r            = m_r;
    m_in_s.muler_hi     = m_muler_hi;
    m_in_s.muler_lo     = m_muler_lo;
  end

  // MEM/WB register: flush inserts a bubble and beats stall; stall holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_r <= '0;
    end else if (flush) begin
      wb_r <= '0;
    end else if (stall) begin
      wb_r <= wb_r;
    end else begin
      wb_r <= m_in_s;
    end
  end

  // An instruction commits HI/LO only on the edge where it leaves WB.
  assign commit_s = wb_r.valid & ~stall;

  // Next HI/LO candidates selected by the instruction in WB.
  always_comb begin
    hi_next_s = hi_r;
    lo_next_s = lo_r;
    case (wb_r.hisource)
      HI_SRC_A:    hi_next_s = wb_r.a;
      HI_SRC_MUL:  hi_next_s = wb_r.muler_hi;
      HI_SRC_R:    hi_next_s = wb_r.r;
      HI_SRC_HOLD: hi_next_s = hi_r;
      default:     hi_next_s = hi_r;
    endcase
    case (wb_r.losource)
      LO_SRC_A:    lo_next_s = wb_r.a;
      LO_SRC_MUL:  lo_next_s = wb_r.muler_lo;
      LO_SRC_Q:    lo_next_s = wb_r.q;
      LO_SRC_HOLD: lo_next_s = lo_r;
      default:     lo_next_s = lo_r;
    endcase
  end

  // Architectural HI register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r <= 32'h0000_0000;
    end else if (commit_s & wb_r.w_hi) begin
      hi_r <= hi_next_s;
    end else begin
      hi_r <= hi_r;
    end
  end

  // Architectural LO register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_r <= 32'h0000_0000;
    end else if (commit_s & wb_r.w_lo) begin
      lo_r <= lo_next_s;
    end else begin
      lo_r <= lo_r;
    end
  end

  pipe_load_cutter u_cutter (
    .dm      (wb_r.dm),
    .addr_lo (wb_r.alu[1:0]),
    .size    (wb_r.cuttersource),
    .sign    (wb_r.sign),
    .cut     (cut_s)
  );

  // Writeback data select; mfhi/mflo see HI/LO before any same-edge update.
  always_comb begin
    rf_wdata = wb_r.alu;
    case (wb_r.rfsource)
      RF_SRC_ALU:   rf_wdata = wb_r.alu;
      RF_SRC_DM:    rf_wdata = cut_s;
      RF_SRC_PC4:   rf_wdata = wb_r.pc4;
      RF_SRC_HI:    rf_wdata = hi_r;
      RF_SRC_LO:    rf_wdata = lo_r;
      RF_SRC_CP0:   rf_wdata = wb_r.cp0;
      RF_SRC_CNT:   rf_wdata = wb_r.counter;
      RF_SRC_MULLO: rf_wdata = wb_r.muler_lo;
      default:      rf_wdata = wb_r.alu;
    endcase
  end

  // Register-file write port; r0 is never written.
  assign rf_we    = wb_r.valid & wb_r.w_rf & (wb_r.rn != 5'd0);
  assign rf_waddr = wb_r.rn;
  assign wb_valid = wb_r.valid;
  assign hi_q     = hi_r;
  assign lo_q     = lo_r;

endmodule

// File: tb/tb_pipe_wb_stage.sv
// Directed self-checking bench for pipe_wb_stage.
module tb_pipe_wb_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        m_valid, m_w_rf, m_w_hi, m_w_lo, m_sign;
  logic [2:0]  m_rfsource;
  logic [1:0]  m_cuttersource, m_hisource, m_losource;
  logic [4:0]  m_rn;
  logic [31:0] m_alu, m_a, m_dm, m_pc4, m_cp0, m_counter, m_q, m_r, m_muler_hi, m_muler_lo;
  logic        rf_we, wb_valid;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, hi_q, lo_q;

  int total = 0;
  int bad   = 0;

  pipe_wb_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_w_rf(m_w_rf), .m_w_hi(m_w_hi), .m_w_lo(m_w_lo),
    .m_sign(m_sign), .m_rfsource(m_rfsource), .m_cuttersource(m_cuttersource),
    .m_hisource(m_hisource), .m_losource(m_losource), .m_rn(m_rn),
    .m_alu(m_alu), .m_a(m_a), .m_dm(m_dm), .m_pc4(m_pc4), .m_cp0(m_cp0),
    .m_counter(m_counter), .m_q(m_q), .m_r(m_r),
    .m_muler_hi(m_muler_hi), .m_muler_lo(m_muler_lo),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .hi_q(hi_q), .lo_q(lo_q), .wb_valid(wb_valid)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_m();
    stall = 1'b0; flush = 1'b0;
    m_valid = 1'b0; m_w_rf = 1'b0; m_w_hi = 1'b0; m_w_lo = 1'b0; m_sign = 1'b0;
    m_rfsource = 3'd0; m_cuttersource = 2'b00; m_hisource = 2'b11; m_losource = 2'b11;
    m_rn = 5'd0; m_alu = 32'h0; m_a = 32'h0; m_dm = 32'h0; m_pc4 = 32'h0;
    m_cp0 = 32'h0; m_counter = 32'h0; m_q = 32'h0; m_r = 32'h0;
    m_muler_hi = 32'h0; m_muler_lo = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_m();
    m_valid = 1'b1; m_w_rf = 1'b1; m_rn = 5'd7; m_alu = 32'h1234;
    tick();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%0b exp=0", rf_we); end
    total++; if (rf_waddr !== 5'd0) begin bad++; $display("FAIL reset_waddr got=%0d exp=0", rf_waddr); end
    total++; if (rf_wdata !== 32'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", wb_valid); end
    total++; if (hi_q !== 32'h0 || lo_q !== 32'h0) begin bad++; $display("FAIL reset_hilo got=%h/%h exp=0/0", hi_q, lo_q); end
    rst = 1'b0;
    clear_m();
    tick();
  endtask

  task automatic test_load_cut();
    logic [31:0] dm_v [6];
    logic [31:0] alu_v [6];
    logic [1:0]  cut_v [6];
    logic        sgn_v [6];
    logic [31:0] exp_v [6];
    dm_v = '{32'h12803456, 32'h12803456, 32'h12803456, 32'h12808456, 32'h92803456, 32'hF0E0D0C0};
    alu_v = '{32'h1001, 32'h1002, 32'h1002, 32'h1001, 32'h1003, 32'h1003};
    cut_v = '{2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b11};
    sgn_v = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp_v = '{32'h00000034, 32'hFFFFFF80, 32'h00001280, 32'hFFFF8456, 32'h00000092, 32'hF0E0D0C0};
    for (int i = 0; i < 6; i++) begin
      clear_m();
      m_valid = 1'b1; m_w_rf = 1'b1; m_rfsource = 3'd1; m_rn = 5'd8;
      m_dm = dm_v[i]; m_alu = alu_v[i]; m_cuttersource = cut_v[i]; m_sign = sgn_v[i];
      tick();
      total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd8) begin bad++; $display("FAIL load_port[%0d] we=%0b addr=%0d exp we=1 addr=8", i, rf_we, rf_waddr); end
      total++; if (rf_wdata !== exp_v[i]) begin bad++; $display("FAIL load_data[%0d] got=%h exp=%h", i, rf_wdata, exp_v[i]); end
    end
    clear_m();
    tick();
  endtask

  task automatic test_rf_sources();
    logic [2:0]  src_v [5];
    logic [31:0] exp_v [5];
    src_v = '{3'd0, 3'd2, 3'd5, 3'd6, 3'd7};
    exp_v = '{32'hA0A0A0A0, 32'h00400004, 32'hC0C0C0C0, 32'h0000CC01, 32'h5A5A5A5A};
    for (int i = 0; i < 5; i++) begin
      clear_m();
      m_valid = 1'b1; m_w_rf = 1'b1; m_rn = 5'd12; m_rfsource = src_v[i];
      m_alu = 32'hA0A0A0A0; m_pc4 = 32'h00400004; m_cp0 = 32'hC0C0C0C0;
      m_counter = 32'h0000CC01; m_muler_lo = 32'h5A5A5A5A; m_dm = 32'hFFFFFFFF;
      tick();
      total++; if (rf_wdata !== exp_v[i]) begin bad++; $display("FAIL rfsrc[%0d] got=%h exp=%h", i, rf_wdata, exp_v[i]); end
    end
    clear_m();
    tick();
  endtask

  task automatic test_mult();
    clear_m();
    m_valid = 1'b1; m_w_hi = 1'b1; m_w_lo = 1'b1; m_hisource = 2'b01; m_losource = 2'b01;
    m_muler_hi = 32'h0000DEAD; m_muler_lo = 32'h0000BEEF;
    tick();
    total++; if (hi_q !== 32'h0 || lo_q !== 32'h0) begin bad++; $display("FAIL mult_early got=%h/%h exp=0/0", hi_q, lo_q); end
    clear_m();
    m_valid = 1'b1; m_w_rf = 1'b1; m_rfsource = 3'd4; m_rn = 5'd9;
    tick();
    total++; if (hi_q !== 32'h0000DEAD || lo_q !== 32'h0000BEEF) begin bad++; $display("FAIL mult_commit got=%h/%h exp=0000dead/0000beef", hi_q, lo_q); end
    total++; if (rf_we !== 1'b1 || rf_wdata !== 32'h0000BEEF) begin bad++; $display("FAIL mflo we=%0b got=%h exp=0000beef", rf_we, rf_wdata); end
    clear_m();
    m_valid = 1'b1; m_w_rf = 1'b1; m_rfsource = 3'd3; m_rn = 5'd9;
    tick();
    total++; if (rf_wdata !== 32'h0000DEAD) begin bad++; $display("FAIL mfhi got=%h exp=0000dead", rf_wdata); end
    // mthi followed directly by mfhi
    clear_m();
    m_valid = 1'b1; m_w_hi = 1'b1; m_hisource = 2'b00; m_a = 32'h11112222;
    m_w_rf = 1'b1; m_rfsource = 3'd3; m_rn = 5'd10;
    tick();
    total++; if (rf_wdata !== 32'h0000DEAD) begin bad++; $display("FAIL mthi_own_read got=%h exp=0000dead", rf_wdata); end
    clear_m();
    m_valid = 1'b1; m_w_rf = 1'b1; m_rfsource = 3'd3; m_rn = 5'd10;
    tick();
    total++; if (rf_wdata !== 32'h11112222) begin bad++; $display("FAIL mthi_mfhi got=%h exp=11112222", rf_wdata); end
    total++; if (lo_q !== 32'h0000BEEF) begin bad++; $display("FAIL lo_untouched got=%h exp=0000beef", lo_q); end
    clear_m();
    tick();
  endtask

  task automatic test_stall_flush();
    clear_m();
    m_valid = 1'b1; m_w_rf = 1'b1; m_rfsource = 3'd0; m_rn = 5'd3; m_alu = 32'h0000A5A5;
    m_w_hi = 1'b1; m_hisource = 2'b00; m_a = 32'h00000077;
    tick();
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      m_alu = 32'hFFFF0000 + i; m_rn = 5'd4; m_a = 32'h99;
      tick();
      total++; if (rf_wdata !== 32'h0000A5A5 || rf_waddr !== 5'd3 || rf_we !== 1'b1) begin bad++; $display("FAIL stall_hold[%0d] data=%h addr=%0d we=%0b exp a5a5/3/1", i, rf_wdata, rf_waddr, rf_we); end
      total++; if (hi_q !== 32'h11112222) begin bad++; $display("FAIL stall_hi[%0d] got=%h exp=11112222", i, hi_q); end
    end
    clear_m();
    tick();
    total++; if (hi_q !== 32'h00000077 || wb_valid !== 1'b0) begin bad++; $display("FAIL stall_release hi=%h valid=%0b exp 77/0", hi_q, wb_valid); end
    m_valid = 1'b1; m_w_rf = 1'b1; m_rn = 5'd6; m_alu = 32'h1;
    tick();
    stall = 1'b1; flush = 1'b1;
    tick();
    total++; if (wb_valid !== 1'b0 || rf_we !== 1'b0 || rf_wdata !== 32'h0) begin bad++; $display("FAIL stall_flush valid=%0b we=%0b data=%h exp 0/0/0", wb_valid, rf_we, rf_wdata); end
    clear_m();
    tick();
  endtask

  task automatic test_r0();
    clear_m();
    m_valid = 1'b1; m_w_rf = 1'b1; m_rn = 5'd0; m_alu = 32'h55;
    tick();
    total++; if (rf_we !== 1'b0 || wb_valid !== 1'b1) begin bad++; $display("FAIL r0_suppress we=%0b valid=%0b exp 0/1", rf_we, wb_valid); end
    m_valid = 1'b0; m_rn = 5'd5;
    tick();
    total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL bubble_we got=%0b exp=0", rf_we); end
    clear_m();
    tick();
  endtask

  task automatic test_div_hold();
    clear_m();
    m_valid = 1'b1; m_w_hi = 1'b1; m_w_lo = 1'b1; m_hisource = 2'b10; m_losource = 2'b10;
    m_r = 32'd3; m_q = 32'd7; m_a = 32'hAA; m_muler_hi = 32'hBB; m_muler_lo = 32'hCC;
    tick();
    clear_m();
    tick();
    total++; if (hi_q !== 32'd3 || lo_q !== 32'd7) begin bad++; $display("FAIL div_commit got=%h/%h exp=3/7", hi_q, lo_q); end
    m_valid = 1'b1; m_w_hi = 1'b1; m_hisource = 2'b11; m_r = 32'd9; m_a = 32'd9; m_muler_hi = 32'd9;
    tick();
    clear_m();
    tick();
    total++; if (hi_q !== 32'd3) begin bad++; $display("FAIL hi_hold got=%h exp=3", hi_q); end
  endtask

  task automatic test_mid_reset();
    clear_m();
    m_valid = 1'b1; m_w_rf = 1'b1; m_w_lo = 1'b1; m_losource = 2'b00; m_a = 32'h44;
    m_rfsource = 3'd1; m_rn = 5'd11; m_dm = 32'hCAFEF00D;
    tick();
    total++; if (rf_we !== 1'b1 || rf_wdata !== 32'hCAFEF00D) begin bad++; $display("FAIL lw_before_reset we=%0b data=%h exp 1/cafef00d", rf_we, rf_wdata); end
    #2 rst = 1'b1;
    #1;
    total++; if (rf_we !== 1'b0 || wb_valid !== 1'b0 || hi_q !== 32'h0 || lo_q !== 32'h0) begin bad++; $display("FAIL async_reset we=%0b valid=%0b hi=%h lo=%h exp all 0", rf_we, wb_valid, hi_q, lo_q); end
    clear_m();
    tick();
    rst = 1'b0;
    tick();
    total++; if (lo_q !== 32'h0) begin bad++; $display("FAIL reset_drops_lo got=%h exp=0", lo_q); end
  endtask

  initial begin
    test_reset();
    test_load_cut();
    test_rf_sources();
    test_mult();
    test_stall_flush();
    test_r0();
    test_div_hold();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
